// File: rtl/serial_adder_datapath_if.sv
// ---------------------------------------------------------------------------
// serial_adder_datapath_if
// Control/operand/result bundle between the serial adder control FSM
// (master) and the bit-serial datapath (slave).
//   Master drives : load, shift, count_en, a_in, b_in, cin, sub
//   Slave drives  : count_done, sum, cout, overflow, sum_valid
// ---------------------------------------------------------------------------
interface serial_adder_datapath_if #(
    parameter int WIDTH = 32
);
    logic             load;
    logic             shift;
    logic             count_en;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             sub;
    logic             count_done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             sum_valid;

    modport master (
        output load, shift, count_en, a_in, b_in, cin, sub,
        input  count_done, sum, cout, overflow, sum_valid
    );

    modport slave (
        input  load, shift, count_en, a_in, b_in, cin, sub,
        output count_done, sum, cout, overflow, sum_valid
    );
endinterface

// File: rtl/serial_adder_datapath.sv
// ---------------------------------------------------------------------------
// serial_adder_datapath
// Bit-serial adder datapath: captures two operands on load, then adds one
// bit per shift cycle (LSB first) through a single full adder and a carry
// flop. A saturating bit counter advanced by count_en reports count_done
// to the control FSM. After WIDTH shifts, sum/cout/overflow are final and
// sum_valid is set until the next load.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset (all state to 0)
//   bus  - serial_adder_datapath_if.slave (control, operands, results)
//
// Optional feature macro: SERIAL_SUB_EN
//   defined   : sub=1 at load computes A-B (B inverted, carry forced to 1)
//   undefined : sub is ignored, always computes A+B+cin
// ---------------------------------------------------------------------------
module serial_adder_datapath #(
    parameter int WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst,
    serial_adder_datapath_if.slave bus
);

    localparam int             CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    // Majority of three bits: carry-out of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        maj3 = (x & y) | (x & z) | (y & z);
    endfunction

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             sum_valid_q, sum_valid_d;

    logic             fa_sum_s;
    logic             fa_carry_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;

    // Operand B and initial carry as captured on load (optionally subtract).
    always_comb begin
        b_load_s     = bus.b_in;
        carry_load_s = bus.cin;
`ifdef SERIAL_SUB_EN
        if (bus.sub) begin
            b_load_s     = ~bus.b_in;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = bus.b_in;
            carry_load_s = bus.cin;
        end
`endif
    end

`ifndef SERIAL_SUB_EN
    // sub is part of the shared bus but has no effect in this build.
    logic unused_sub_s;
    assign unused_sub_s = bus.sub;
`endif

    // Single full adder on the current LSBs.
    always_comb begin
        fa_sum_s   = a_q[0] ^ b_q[0] ^ carry_q;
        fa_carry_s = maj3(a_q[0], b_q[0], carry_q);
    end

    // Next-state logic: load has priority; shifts stop once the result is valid.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        sum_valid_d = sum_valid_q;

        if (bus.load) begin
            a_d         = bus.a_in;
            b_d         = b_load_s;
            carry_d     = carry_load_s;
            sum_d       = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            sum_valid_d = 1'b0;
        end else begin
            if (bus.shift && !sum_valid_q) begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sum_d   = {fa_sum_s, sum_q[WIDTH-1:1]};
                carry_d = fa_carry_s;
                // MSB step: carry-in to MSB is carry_q, carry-out is fa_carry_s.
                if (count_q == CNT_MAX) begin
                    overflow_d  = carry_q ^ fa_carry_s;
                    sum_valid_d = 1'b1;
                end else begin
                    overflow_d  = overflow_q;
                    sum_valid_d = sum_valid_q;
                end
            end else begin
                a_d     = a_q;
                b_d     = b_q;
                sum_d   = sum_q;
                carry_d = carry_q;
            end

            if (bus.count_en) begin
                if (count_q == CNT_MAX) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign bus.count_done = (count_q == CNT_MAX);
    assign bus.sum        = sum_q;
    assign bus.cout       = carry_q;
    assign bus.overflow   = overflow_q;
    assign bus.sum_valid  = sum_valid_q;

endmodule

// File: tb/tb_serial_adder_datapath.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_datapath
// Directed self-checking bench for serial_adder_datapath (WIDTH=32).
// ---------------------------------------------------------------------------
module tb_serial_adder_datapath;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    serial_adder_datapath_if #(.WIDTH(W)) bus ();

    serial_adder_datapath #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.load     = 1'b0;
        bus.shift    = 1'b0;
        bus.count_en = 1'b0;
    endtask

    // Load operands, then run W shift+count_en cycles checking count_done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input string tag);
        bus.a_in = a;
        bus.b_in = b;
        bus.cin  = c;
        bus.sub  = s;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check({tag, "_valid_after_load"}, {31'd0, bus.sum_valid}, 32'd0);
        for (int i = 0; i < W; i++) begin
            bus.shift    = 1'b1;
            bus.count_en = 1'b1;
            #1;
            check($sformatf("%s_count_done_%0d", tag, i), {31'd0, bus.count_done},
                  (i == W - 1) ? 32'd1 : 32'd0);
            check($sformatf("%s_valid_early_%0d", tag, i), {31'd0, bus.sum_valid}, 32'd0);
            tick();
        end
        idle_inputs();
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es,
                                input logic ec, input logic eo);
        check({tag, "_sum"}, bus.sum, es);
        check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
        check({tag, "_valid"}, {31'd0, bus.sum_valid}, 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        bus.a_in = 32'd0;
        bus.b_in = 32'd0;
        bus.cin  = 1'b0;
        bus.sub  = 1'b0;
        rst = 1'b1;
        #12;
        check("rst_sum", bus.sum, 32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        check("rst_valid", {31'd0, bus.sum_valid}, 32'd0);
        check("rst_done", {31'd0, bus.count_done}, 32'd0);
        rst = 1'b0;
        tick();

        // 5 + 3
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, "add5_3");
        check_result("add5_3", 32'h0000_0008, 1'b0, 1'b0);

        // Unsigned wrap: carry out, no signed overflow
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap");
        check_result("wrap", 32'h0000_0000, 1'b1, 1'b0);

        // Signed overflow
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ovf");
        check_result("ovf", 32'h8000_0000, 1'b0, 1'b1);

        // Extra shifts after completion are ignored; counter stays saturated
        for (int i = 0; i < 5; i++) begin
            bus.shift    = 1'b1;
            bus.count_en = 1'b1;
            tick();
            check($sformatf("post_sum_%0d", i), bus.sum, 32'h8000_0000);
            check($sformatf("post_cout_%0d", i), {31'd0, bus.cout}, 32'd0);
            check($sformatf("post_done_%0d", i), {31'd0, bus.count_done}, 32'd1);
            check($sformatf("post_valid_%0d", i), {31'd0, bus.sum_valid}, 32'd1);
        end

        // Load together with shift while valid: load wins, result discarded
        bus.a_in = 32'h0000_0005;
        bus.b_in = 32'h0000_0003;
        bus.cin  = 1'b1;
        bus.load = 1'b1;
        tick();
        idle_inputs();
        check("ldsh_sum", bus.sum, 32'd0);
        check("ldsh_cout", {31'd0, bus.cout}, 32'd1);
        check("ldsh_valid", {31'd0, bus.sum_valid}, 32'd0);
        check("ldsh_done", {31'd0, bus.count_done}, 32'd0);
        check("ldsh_ovf", {31'd0, bus.overflow}, 32'd0);
        // Count is 0: exactly 31 more shifts must leave it at WIDTH-1 (done high)
        for (int i = 0; i < W - 1; i++) begin
            bus.shift    = 1'b1;
            bus.count_en = 1'b1;
            tick();
        end
        idle_inputs();
        check("ldsh_done_31", {31'd0, bus.count_done}, 32'd1);
        check("ldsh_valid_31", {31'd0, bus.sum_valid}, 32'd0);
        bus.shift    = 1'b1;
        bus.count_en = 1'b1;
        tick();
        idle_inputs();
        check_result("ldsh", 32'h0000_0009, 1'b0, 1'b0);

        // Asynchronous reset mid-operation (count = 10)
        bus.a_in = 32'h1234_5678;
        bus.b_in = 32'h0F0F_0F0F;
        bus.cin  = 1'b1;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.shift    = 1'b1;
            bus.count_en = 1'b1;
            tick();
        end
        idle_inputs();
        check("mid_sum_nonzero", {31'd0, (bus.sum != 32'd0)}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_sum", bus.sum, 32'd0);
        check("arst_cout", {31'd0, bus.cout}, 32'd0);
        check("arst_ovf", {31'd0, bus.overflow}, 32'd0);
        check("arst_valid", {31'd0, bus.sum_valid}, 32'd0);
        check("arst_done", {31'd0, bus.count_done}, 32'd0);
        #1;
        rst = 1'b0;
        tick();

        // Subtract request: depends on build configuration
        run_op(32'd10, 32'd3, 1'b0, 1'b1, "sub");
`ifdef SERIAL_SUB_EN
        check_result("sub", 32'd7, 1'b1, 1'b0);
`else
        check_result("sub", 32'd13, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_datapath.md
# serial_adder_datapath

Bit-serial datapath for the 32-bit serial adder, sitting directly downstream of the adder control FSM. It captures two operands on `load`, then adds them one bit per `shift` cycle, LSB first, through a single full adder and a carry flop. A bit counter advanced by `count_en` returns `count_done` to the FSM. After exactly WIDTH shifts it presents the sum, the carry-out and the signed-overflow flag.

## Interface
- WIDTH, 32, operand/sum width; legal range WIDTH ≥ 2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load  in  1  capture operands, clear result state
- shift  in  1  perform one serial bit-add step
- count_en  in  1  advance the bit counter
- a_in  in  WIDTH  operand A, sampled on load
- b_in  in  WIDTH  operand B, sampled on load
- cin  in  1  carry-in, sampled on load
- sub  in  1  subtract request, sampled on load; behaviour set by the macro described under Configuration
- count_done  out  1  combinational; high while count == WIDTH-1
- sum  out  WIDTH  sum shift register, direct output; holds a partial result while shifting
- cout  out  1  carry flop
- overflow  out  1  signed overflow, registered
- sum_valid  out  1  high after the WIDTH-th shift, until the next load

## Operation
- Registers:
  - A and B shift registers (WIDTH each)
  - sum register (WIDTH)
  - carry flop
  - counter, $clog2(WIDTH) bits
  - overflow flop
  - sum_valid flop
- Reset values: every register is 0. Resulting outputs: sum=0, cout=0, overflow=0, sum_valid=0, count_done=0.
- load (highest priority) loads:
  - A←a_in, B←b_in, carry←cin
  - sum←0, count←0, overflow←0, sum_valid←0
- shift while load=0 and sum_valid=0:
  - s = A[0]^B[0]^carry
  - carry ← maj(A[0],B[0],carry)
  - A←A>>1 and B←B>>1 (zero fill)
  - sum←{s, sum[WIDTH-1:1]}
- shift while sum_valid=1 is ignored. A, B, sum and carry hold.
- Final step: a shift with count==WIDTH-1 is the final step.
  - overflow ← carry_in_to_MSB ^ carry_out_of_MSB, i.e. the carry flop value before the step XOR the majority result.
  - sum_valid←1.
- count_en while load=0: count←count+1, saturating at WIDTH-1. count_en and shift are independent inputs. The FSM asserts them together.
- count_done = (count == WIDTH-1). It stays high while count is held at saturation.

## Timing
- load cycle N: operands are visible internally at N+1, with count=0.
- FSM ADD state: shift=count_en=1 on cycles N+1 … N+WIDTH.
  - count_done is high during cycle N+WIDTH.
  - The FSM leaves ADD on that edge, so exactly WIDTH shifts occur.
- Results after the edge ending cycle N+WIDTH:
  - sum, cout and overflow are final.
  - sum_valid=1.
  - Latency from load to sum_valid is WIDTH+1 cycles.
- load and shift in the same cycle: load wins and the shift is dropped.
- Reset mid-operation: all outputs are 0 immediately on rst assertion, with no clock needed. Operation restarts only on a new load.
- Back-to-back load while sum_valid=1: the result is discarded and sum_valid goes to 0 on the next edge.

## Configuration
- SERIAL_SUB_EN defined:
  - When sub=1 at load: B←~b_in and carry←1; cin is ignored. The sum is A−B, and cout=1 means no borrow.
  - When sub=0: normal add.
- SERIAL_SUB_EN undefined: the sub port is present but ignored. The block always computes A+B+cin.

## Test plan
- WIDTH=32, a=0x00000005, b=0x00000003, cin=0, load then 32 shift+count_en cycles:
  - count_done high only in the 32nd cycle.
  - Result: sum=0x00000008, cout=0, overflow=0, sum_valid=1 one edge later.
- a=0xFFFFFFFF, b=0x00000001, cin=0, full run → sum=0x00000000, cout=1, overflow=0.
- a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, overflow=1.
- Priority and post-completion checks:
  - load and shift asserted together: registers show the loaded values and count=0.
  - 5 extra shifts after sum_valid: sum and cout unchanged, count held at 31, count_done stays 1.
- rst pulsed asynchronously at count=10 → sum=0, cout=0, overflow=0, sum_valid=0, count_done=0 before the next clock edge.
- a=10, b=3, sub=1:
  - With SERIAL_SUB_EN: sum=7, cout=1.
  - Without SERIAL_SUB_EN (cin=0): sum=13, cout=0.
